// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default bit timing and the
// ASCII line-ending constants also used by the command state machine.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    localparam logic [7:0] ASCII_CR = 8'd13;
    localparam logic [7:0] ASCII_LF = 8'd10;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for bringing an asynchronous pin into the
// clk domain; both flops reset to RESET_VALUE.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronises the line, qualifies the start bit, takes a
// 3-sample majority vote at each bit centre and flags framing errors.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_FE,
    output logic       o_Rx_Busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    logic             rx_s;
    logic [2:0]       hist;
    logic             maj;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (i_Rx_Serial),
        .q  (rx_s)
    );

    assign maj       = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign o_Rx_Busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hist      <= 3'b111;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            o_Rx_Byte <= '0;
            o_Rx_DV   <= 1'b0;
            o_Rx_FE   <= 1'b0;
        end else begin
            hist    <= {hist[1:0], rx_s};
            o_Rx_DV <= 1'b0;
            o_Rx_FE <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                // A start bit that is no longer low at its centre was a glitch
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= maj ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        shift[bit_idx] <= maj;
                        cnt            <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Leaving mid stop bit lets the next start edge be caught with no gap
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (maj) begin
                            o_Rx_Byte <= shift;
                            o_Rx_DV   <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            o_Rx_FE <= 1'b1;
                            state   <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clocks per bit; expected
// bytes, pulse counts and latencies are hand-computed constants.
module tb_uart_rx_deserializer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_Rx_Serial = 1'b1;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_FE;
    logic       o_Rx_Busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int busy_cnt = 0;
    int last_fall_cyc = 0;
    int dv_cyc_q[$];
    logic [7:0] dv_byte_q[$];

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_Rx_Serial(i_Rx_Serial),
        .o_Rx_DV    (o_Rx_DV),
        .o_Rx_Byte  (o_Rx_Byte),
        .o_Rx_FE    (o_Rx_FE),
        .o_Rx_Busy  (o_Rx_Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output events are recorded half a cycle after the edge that produced them
    always @(negedge clk) begin
        if (o_Rx_DV) begin
            dv_cnt++;
            dv_cyc_q.push_back(cyc);
            dv_byte_q.push_back(o_Rx_Byte);
        end
        if (o_Rx_FE) fe_cnt++;
        if (o_Rx_DV && o_Rx_FE) both_cnt++;
        if (o_Rx_Busy) busy_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; glitch_bit inverts one cycle near the centre of that data bit
    task automatic applyStimulus(input logic [7:0] data, input int glitch_bit,
                                 input logic stop_level, input int stop_bits);
        logic level;
        int   len;
        last_fall_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            level = (i == 0) ? 1'b0 : (i == 9) ? stop_level : data[i-1];
            len   = (i == 9) ? CPB * stop_bits : CPB;
            for (int c = 0; c < len; c++) begin
                i_Rx_Serial = ((i - 1 == glitch_bit) && (c == 6)) ? ~level : level;
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int dv0;
        int fe0;
        int busy0;
        int n0;

        waitCycles(3);
        rst = 1'b0;
        checkOutput("reset_dv", o_Rx_DV, 1'b0);
        checkOutput("reset_fe", o_Rx_FE, 1'b0);
        checkOutput("reset_busy", o_Rx_Busy, 1'b0);
        checkOutput("reset_byte", o_Rx_Byte, 8'h00);

        // good frame with latency check
        waitCycles(5);
        dv0 = dv_cnt; fe0 = fe_cnt; n0 = dv_cyc_q.size();
        applyStimulus(8'hA5, -1, 1'b1, 1);
        waitCycles(5);
        checkOutput("a5_dv_count", dv_cnt - dv0, 1);
        checkOutput("a5_fe_count", fe_cnt - fe0, 0);
        checkOutput("a5_byte", o_Rx_Byte, 8'hA5);
        if (dv_cyc_q.size() > n0)
            checkOutput("a5_latency", dv_cyc_q[n0] - last_fall_cyc, 155);

        // start-bit glitch
        dv0 = dv_cnt; fe0 = fe_cnt; busy0 = busy_cnt;
        i_Rx_Serial = 1'b0;
        waitCycles(3);
        i_Rx_Serial = 1'b1;
        waitCycles(30);
        checkOutput("glitch_dv_count", dv_cnt - dv0, 0);
        checkOutput("glitch_fe_count", fe_cnt - fe0, 0);
        checkOutput("glitch_busy_cycles", busy_cnt - busy0, 8);

        // single-cycle inversion inside the vote window of bit 2
        dv0 = dv_cnt;
        applyStimulus(8'h3C, 2, 1'b1, 1);
        waitCycles(5);
        checkOutput("centre_glitch_dv_count", dv_cnt - dv0, 1);
        checkOutput("centre_glitch_byte", o_Rx_Byte, 8'h3C);

        // framing error with the line held low past the stop bit
        dv0 = dv_cnt; fe0 = fe_cnt;
        applyStimulus(8'h55, -1, 1'b0, 2);
        checkOutput("fe_pulse_count", fe_cnt - fe0, 1);
        checkOutput("fe_dv_count", dv_cnt - dv0, 0);
        checkOutput("fe_byte_kept", o_Rx_Byte, 8'h3C);
        checkOutput("fe_wait_high_busy", o_Rx_Busy, 1'b1);
        i_Rx_Serial = 1'b1;
        waitCycles(6);
        checkOutput("fe_release_busy", o_Rx_Busy, 1'b0);
        checkOutput("fe_release_fe_count", fe_cnt - fe0, 1);
        dv0 = dv_cnt;
        applyStimulus(8'h0D, -1, 1'b1, 1);
        waitCycles(5);
        checkOutput("after_fe_dv_count", dv_cnt - dv0, 1);
        checkOutput("after_fe_byte", o_Rx_Byte, 8'h0D);

        // back-to-back frames with no idle gap
        n0 = dv_cyc_q.size();
        applyStimulus(8'h31, -1, 1'b1, 1);
        applyStimulus(8'h0D, -1, 1'b1, 1);
        waitCycles(10);
        checkOutput("b2b_dv_count", dv_cyc_q.size() - n0, 2);
        if (dv_cyc_q.size() >= n0 + 2) begin
            checkOutput("b2b_byte0", dv_byte_q[n0], 8'h31);
            checkOutput("b2b_byte1", dv_byte_q[n0+1], 8'h0D);
            checkOutput("b2b_spacing", dv_cyc_q[n0+1] - dv_cyc_q[n0], 160);
        end

        // reset pulse during bit 4 of 0xFF
        dv0 = dv_cnt; fe0 = fe_cnt;
        fork
            applyStimulus(8'hFF, -1, 1'b1, 1);
            begin
                waitCycles(5 * CPB + 8);
                rst = 1'b1;
                waitCycles(1);
                rst = 1'b0;
                checkOutput("midrst_dv", o_Rx_DV, 1'b0);
                checkOutput("midrst_fe", o_Rx_FE, 1'b0);
                checkOutput("midrst_busy", o_Rx_Busy, 1'b0);
                checkOutput("midrst_byte", o_Rx_Byte, 8'h00);
            end
        join
        waitCycles(5);
        checkOutput("midrst_no_dv", dv_cnt - dv0, 0);
        checkOutput("midrst_no_fe", fe_cnt - fe0, 0);
        dv0 = dv_cnt;
        applyStimulus(8'h42, -1, 1'b1, 1);
        waitCycles(5);
        checkOutput("post_rst_dv_count", dv_cnt - dv0, 1);
        checkOutput("post_rst_byte", o_Rx_Byte, 8'h42);

        checkOutput("dv_fe_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receives asynchronous 8N1 UART serial data from the board pin and delivers one byte per frame to the UART command state machine (the `i_Rx_DV` and `i_Rx_Byte` inputs of the menu/flash-programming controller).

The block:
- synchronises the raw line,
- validates the start bit against glitches,
- samples each bit at its centre with 3-sample majority voting,
- checks the stop bit, flagging bad frames without issuing a data-valid.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Must be an even number ≥ 8.
- `CNT_W`, default `$clog2(CLKS_PER_BIT)`: bit-period counter width.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `i_Rx_Serial`, input, 1: raw, asynchronous serial line. Idle level is high.
- `o_Rx_DV`, output, 1: one-cycle pulse; `o_Rx_Byte` is valid on this cycle.
- `o_Rx_Byte`, output, 8: last good received byte, LSB-first assembled. Held until the next good frame.
- `o_Rx_FE`, output, 1: one-cycle pulse on a framing error (stop bit sampled low).
- `o_Rx_Busy`, output, 1: high from the cycle after a start edge is detected until the return to IDLE.

## Operation
- **Synchroniser:** `i_Rx_Serial` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- **Vote history:** a 3-bit history `hist` holds the last three `rx_s` values; reset value 3'b111. `maj` is the 2-of-3 majority of `hist`.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:**
  - `cnt` and `bit_idx` are held at 0.
  - When `rx_s` is 0, go to START with `cnt` = 0.
- **START:**
  - `cnt` increments each cycle.
  - At `cnt` == `CLKS_PER_BIT/2 − 1`: if `maj` is 0, go to DATA with `cnt` = 0 and `bit_idx` = 0.
  - Otherwise it is a glitch: go to IDLE. No output pulse.
- **DATA:**
  - At `cnt` == `CLKS_PER_BIT − 1`: `shift[bit_idx]` is loaded with `maj`, and `cnt` is set to 0.
  - If `bit_idx` == 7, go to STOP; otherwise `bit_idx` increments.
- **STOP:** at `cnt` == `CLKS_PER_BIT − 1`:
  - If `maj` is 1: load `o_Rx_Byte` from `shift`, pulse `o_Rx_DV`, go to IDLE.
  - If `maj` is 0: pulse `o_Rx_FE`, leave `o_Rx_Byte` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s` is 1, then go to IDLE. A break condition or a stuck-low line therefore produces exactly one FE pulse and no false start bits.
- **Outputs:**
  - `o_Rx_DV` and `o_Rx_FE` are registered and never asserted in the same cycle.
  - `o_Rx_Busy` is 0 exactly when the state is IDLE.
- **Arithmetic:**
  - `cnt` is unsigned, `CNT_W` bits wide, and compared only with `==`.
  - `bit_idx` is 3 bits.
  - No wrap occurs beyond `CLKS_PER_BIT − 1`.
- **Reset:** reset asserted mid-frame aborts the frame. After reset:
  - State IDLE; `cnt`, `bit_idx` and `shift` are 0.
  - `o_Rx_DV` = 0, `o_Rx_FE` = 0, `o_Rx_Busy` = 0, `o_Rx_Byte` = 8'h00.
  - Synchroniser flops = 1.

## Timing
- Let T be the first cycle in which IDLE sees `rx_s` = 0. The pin fell 2–3 cycles earlier because of the synchroniser.
- START is entered at T+1.
- Start-bit decision is at T + `CLKS_PER_BIT/2`.
- Decision for data bit k (k = 0..7) is at T + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
- Stop decision is at T + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- `o_Rx_DV` or `o_Rx_FE` is high for the single cycle following the stop decision.
- The block is back in IDLE the cycle after the stop decision, which is half a bit before the stop bit ends. Back-to-back frames with zero idle time are therefore received without loss.
- Majority samples cover the decision cycle and the two cycles before it. A single-cycle glitch at the bit centre never corrupts a bit.
- The block has no backpressure. The consumer must accept `o_Rx_DV` on the cycle it is asserted.

## Structure
- Shared package `uart_pkg`:
  - State enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - `CLKS_PER_BIT` default (868).
  - ASCII constants CR (8'd13) and LF (8'd10), also used by the command state machine.
- One sub-module: `sync_2ff`, a 1-bit, 2-flop synchroniser with a reset-value parameter (here 1).

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- **Good frame:** send 0xA5 in 8N1. Required: one `o_Rx_DV` pulse with `o_Rx_Byte` = 8'hA5, `o_Rx_FE` never asserted, and `o_Rx_DV` at T + 8 + 144 + 1.
- **Start glitch:** line low for 3 cycles, then high. Required: START aborts to IDLE, no DV or FE, `o_Rx_Busy` high for 8 cycles only.
- **Bit-centre glitch:** send 0x3C with a 1-cycle inversion at the centre of bit 2. Required: `o_Rx_Byte` = 8'h3C.
- **Framing error:**
  - Send 0x55 with the stop bit held low for 2 bit times. Required: one `o_Rx_FE` pulse, no DV, `o_Rx_Byte` keeps its prior value, and the block stays in WAIT_HIGH until the line goes high.
  - Then send 0x0D. Required: DV with 8'h0D.
- **Back-to-back:** send "1" (0x31) then CR (0x0D) with zero idle between frames. Required: two DV pulses, 160 cycles apart, carrying 0x31 then 0x0D.
- **Reset mid-frame:** assert `rst` for 1 cycle during bit 4 of 0xFF. Required: all outputs at their reset values, no DV for the aborted frame, and the next 0x42 frame is received correctly.
